pred_sample_calc: RTL and testbench
===================================

Name: pred_sample_calc

Overview:
- Downstream neighbour of the dot-product adder tree in the simplified CCSDS-123.0-B-2 predictor.
- Consumes the predicted central local difference d^ (vec) together with the aligned local sum σ.
- Produces the scaled predicted sample s~ and the predicted sample s^ through a 2-stage valid pipeline.
- Handles the first sample of each band (t=0) via a sideband bypass, per the standard.

Parameters:
- D, 12, sample dynamic range in bits; unsigned samples, s_min=0, s_max=2^D-1, s_mid=2^(D-1).
- OMEGA, 16, weight resolution Ω.
- VEC_WIDTH, 49, width of signed input vec; equals the upstream adder-tree output width.
- R, 32, register size for mod*_R; legal range max(32, D+OMEGA+2) ≤ R ≤ 64.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- vec_en  in  1  input valid; single-cycle qualifier, no backpressure.
- vec  in  VEC_WIDTH  signed d^ (two's complement).
- lsum  in  D+2  unsigned local sum σ, aligned with vec_en.
- first_t  in  1  current sample is t=0 of its band.
- band_zero  in  1  current band is z=0, or P*=0.
- prev_band_s  in  D  s_{z-1}(0), used only when first_t=1 and band_zero=0.
- s_tilde_en  out  1  output valid, one-cycle pulse.
- s_tilde  out  D+1  scaled predicted sample.
- s_hat  out  D  predicted sample = s_tilde>>1.

Behaviour:
- Reset: sync, active-low. Next clk edge clears all pipeline registers, s_tilde_en=0, s_tilde=0, s_hat=0. In-flight samples are dropped, and no output pulse occurs for them after reset.
- Latency: fixed 2 cycles. vec_en at edge N gives s_tilde_en high after edge N+2.
- Throughput: one sample per cycle. Back-to-back vec_en is legal.
- Hold: stage registers load only when their stage valid is 1. Outputs hold their last value while s_tilde_en=0.
- Stage 1, on vec_en:
  - diff = lsum - 4*s_mid, signed D+3 bits.
  - term = sext(vec) + (sext(diff) << OMEGA), computed at max(VEC_WIDTH, D+3+OMEGA)+1 bits.
  - m = low R bits of term, reinterpreted signed (mod*_R wrap).
  - first_t, band_zero and prev_band_s are registered alongside.
- Stage 2:
  - q = m >>> (OMEGA+1), arithmetic shift, i.e. floor toward -inf.
  - p = q + 2^D + 1, signed.
  - clip p to [0, 2^(D+1)-1]. Clipping happens at the boundary; exact bound values pass unchanged.
  - If first_t: s_tilde = band_zero ? 2*s_mid : 2*prev_band_s. vec and lsum are ignored.
  - s_hat = s_tilde[D:1].
- Widths: no intermediate truncation except the deliberate mod*_R wrap.
- Sideband flags are sampled only with vec_en. Their values are don't-care otherwise.

Decomposition:
- Shared package pred_pkg holds:
  - constants S_MID, S_TILDE_MAX = 2^(D+1)-1, OFFSET = 2^D+1;
  - function mod_r(value, R), reused by the weight-update stage;
  - width helper functions for D+2, D+3 and the term width.
- Sub-module pred_clip (signed in, range-limited unsigned out) is natural: it is a single combinational block, reused later for residual mapping bounds.
- The pipeline registers stay in pred_sample_calc.

Test Plan:
All scenarios use defaults: D=12, OMEGA=16, R=32.
1. Nominal and latency: vec=0, lsum=8192, first_t=0 -> s_tilde_en high 2 cycles later; s_tilde=4097, s_hat=2048. Then vec=100*2^17, lsum=8192 on the next cycle -> s_tilde=4197, s_hat=2098 on the following cycle (back-to-back).
2. Floor on negatives: vec=-1, lsum=8192 -> s_tilde=4096, s_hat=2048. vec=-2^17, lsum=8192 -> s_tilde=4096.
3. Clip bounds:
   - lsum=16380, vec=0 -> 8191, passes exactly.
   - lsum=16380, vec=10*2^17 -> 8191, s_hat=4095.
   - lsum=0, vec=0 -> 1.
   - lsum=0, vec=-5*2^17 -> 0.
4. mod*_R wrap: vec=2^31, lsum=8192 -> m=-2^31, s_tilde=0. Without the wrap the result would be 8191; the bench flags a missing wrap.
5. First sample:
   - first_t=1, band_zero=0, prev_band_s=1234, vec=random -> s_tilde=2468, s_hat=1234.
   - first_t=1, band_zero=1 -> s_tilde=4096, s_hat=2048.
6. Reset mid-flight: two vec_en pulses, then rst_n=0 for one edge after the first -> no s_tilde_en pulse for either sample; outputs read 0. After release, the next sample returns with nominal 2-cycle latency.

Source files
------------

// File: rtl/pred_pkg.sv
// Shared constants and helpers for the predictor datapath: sample range
// constants, derived widths and the mod*_R wrap used by several stages.
package pred_pkg;

    localparam int unsigned D_DEF = 32'd12;

    function automatic int unsigned s_mid_of(input int unsigned d);
        return 32'd1 << (d - 32'd1);
    endfunction

    function automatic int unsigned s_tilde_max_of(input int unsigned d);
        return (32'd1 << (d + 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned offset_of(input int unsigned d);
        return (32'd1 << d) + 32'd1;
    endfunction

    localparam int unsigned S_MID       = s_mid_of(D_DEF);
    localparam int unsigned S_TILDE_MAX = s_tilde_max_of(D_DEF);
    localparam int unsigned OFFSET      = offset_of(D_DEF);

    function automatic int unsigned lsum_w(input int unsigned d);
        return d + 32'd2;
    endfunction

    function automatic int unsigned diff_w(input int unsigned d);
        return d + 32'd3;
    endfunction

    function automatic int unsigned term_w(input int unsigned vw, input int unsigned d,
                                           input int unsigned om);
        int unsigned m;
        m = (vw > (d + 32'd3 + om)) ? vw : (d + 32'd3 + om);
        return m + 32'd1;
    endfunction

    // Keep the low r bits and sign-extend from bit r-1 (two's complement wrap).
    function automatic logic signed [63:0] mod_r(input logic signed [127:0] value, input int r);
        logic signed [63:0] res;
        res = value[63:0];
        for (int i = 0; i < 64; i++) begin
            if (i >= r) begin
                res[i] = value[r-1];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pred_clip.sv
// Limits a signed value to the unsigned range [0, 2^OUT_W-1]; bounds pass unchanged.
module pred_clip #(
    parameter int unsigned IN_W  = 33,
    parameter int unsigned OUT_W = 13
) (
    input  logic signed [IN_W-1:0] val_i,
    output logic [OUT_W-1:0]       val_o
);

    localparam logic signed [IN_W-1:0] HI = IN_W'((65'd1 << OUT_W) - 65'd1);

    // Saturate below zero and above the upper bound.
    always_comb begin
        val_o = '0;
        if (val_i[IN_W-1]) begin
            val_o = '0;
        end else if (val_i > HI) begin
            val_o = HI[OUT_W-1:0];
        end else begin
            val_o = val_i[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/pred_sample_calc.sv
// Turns the predicted central local difference and local sum into the scaled
// predicted sample s~ and predicted sample s^ through two register stages.
module pred_sample_calc
    import pred_pkg::*;
#(
    parameter int unsigned D         = 12,
    parameter int unsigned OMEGA     = 16,
    parameter int unsigned VEC_WIDTH = 49,
    parameter int unsigned R         = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        vec_en_i,
    input  logic signed [VEC_WIDTH-1:0] vec_i,
    input  logic [D+1:0]                lsum_i,
    input  logic                        first_t_i,
    input  logic                        band_zero_i,
    input  logic [D-1:0]                prev_band_s_i,
    output logic                        s_tilde_en_o,
    output logic [D:0]                  s_tilde_o,
    output logic [D-1:0]                s_hat_o
);

    localparam int unsigned DIFF_W = diff_w(D);
    localparam int unsigned TERM_W = term_w(VEC_WIDTH, D, OMEGA);

    localparam logic signed [DIFF_W-1:0] FOUR_S_MID = DIFF_W'(32'd4 * s_mid_of(D));
    localparam logic [D:0]               TWO_S_MID  = (D+1)'(32'd2 * s_mid_of(D));
    localparam logic signed [R:0]        OFFSET_W   = (R+1)'(offset_of(D));

    logic signed [DIFF_W-1:0] diff_s;
    logic signed [TERM_W-1:0] term_s;
    logic signed [127:0]      term_wide_s;
    logic signed [63:0]       mod_res_s;
    logic signed [R-1:0]      m_d;

    logic signed [R-1:0] m_q;
    logic                v1_q;
    logic                first_q;
    logic                bz_q;
    logic [D-1:0]        prev_q;

    logic signed [R-1:0] q_s;
    logic signed [R:0]   p_s;
    logic [D:0]          clip_s;
    logic [D:0]          s_tilde_d;

    logic       s_tilde_en_q;
    logic [D:0] s_tilde_q;
    logic [D-1:0] s_hat_q;

    // Stage 1 arithmetic: centre the local sum, align it to the weight scale, wrap to R bits.
    always_comb begin
        diff_s      = $signed({1'b0, lsum_i}) - FOUR_S_MID;
        term_s      = TERM_W'(vec_i) + (TERM_W'(diff_s) <<< OMEGA);
        term_wide_s = 128'(term_s);
        mod_res_s   = mod_r(term_wide_s, int'(R));
        m_d         = mod_res_s[R-1:0];
    end

    // Stage 2 arithmetic: floor divide, re-offset, clip, then the t=0 bypass.
    always_comb begin
        q_s = m_q >>> (OMEGA + 32'd1);
        p_s = (R+1)'(q_s) + OFFSET_W;
        if (first_q) begin
            s_tilde_d = bz_q ? TWO_S_MID : {prev_q, 1'b0};
        end else begin
            s_tilde_d = clip_s;
        end
    end

    pred_clip #(
        .IN_W  (R + 32'd1),
        .OUT_W (D + 32'd1)
    ) u_clip (
        .val_i (p_s),
        .val_o (clip_s)
    );

    // Pipeline registers; each stage loads only when its valid is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q         <= 1'b0;
            m_q          <= '0;
            first_q      <= 1'b0;
            bz_q         <= 1'b0;
            prev_q       <= '0;
            s_tilde_en_q <= 1'b0;
            s_tilde_q    <= '0;
            s_hat_q      <= '0;
        end else begin
            v1_q         <= vec_en_i;
            s_tilde_en_q <= v1_q;
            if (vec_en_i) begin
                m_q     <= m_d;
                first_q <= first_t_i;
                bz_q    <= band_zero_i;
                prev_q  <= prev_band_s_i;
            end else begin
                m_q     <= m_q;
                first_q <= first_q;
                bz_q    <= bz_q;
                prev_q  <= prev_q;
            end
            if (v1_q) begin
                s_tilde_q <= s_tilde_d;
                s_hat_q   <= s_tilde_d[D:1];
            end else begin
                s_tilde_q <= s_tilde_q;
                s_hat_q   <= s_hat_q;
            end
        end
    end

    assign s_tilde_en_o = s_tilde_en_q;
    assign s_tilde_o    = s_tilde_q;
    assign s_hat_o      = s_hat_q;

endmodule

// File: tb/tb_pred_sample_calc.sv
// Directed checks of pred_sample_calc with hand-computed expectations (D=12, OMEGA=16, R=32).
module tb_pred_sample_calc;

    logic               clk;
    logic               rst_n;
    logic               vec_en;
    logic signed [48:0] vec;
    logic [13:0]        lsum;
    logic               first_t;
    logic               band_zero;
    logic [11:0]        prev_band_s;
    logic               s_tilde_en;
    logic [12:0]        s_tilde;
    logic [11:0]        s_hat;

    int n_cmp;
    int n_err;

    pred_sample_calc dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vec_en_i      (vec_en),
        .vec_i         (vec),
        .lsum_i        (lsum),
        .first_t_i     (first_t),
        .band_zero_i   (band_zero),
        .prev_band_s_i (prev_band_s),
        .s_tilde_en_o  (s_tilde_en),
        .s_tilde_o     (s_tilde),
        .s_hat_o       (s_hat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic en, input logic signed [48:0] v, input logic [13:0] l,
                         input logic ft, input logic bz, input logic [11:0] pb);
        vec_en      = en;
        vec         = v;
        lsum        = l;
        first_t     = ft;
        band_zero   = bz;
        prev_band_s = pb;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One isolated sample: checks latency, values, single-cycle pulse and hold.
    task automatic one_sample(input string tag, input logic signed [48:0] v, input logic [13:0] l,
                              input logic ft, input logic bz, input logic [11:0] pb,
                              input logic [12:0] exp_st, input logic [11:0] exp_sh);
        step();
        drive(1'b1, v, l, ft, bz, pb);
        step();
        drive(1'b0, 49'sd0, 14'd0, 1'b0, 1'b0, 12'd0);
        check_val({tag, "_early"}, 64'(s_tilde_en), 64'd0);
        step();
        check_val({tag, "_en"}, 64'(s_tilde_en), 64'd1);
        check_val({tag, "_st"}, 64'(s_tilde), 64'(exp_st));
        check_val({tag, "_sh"}, 64'(s_hat), 64'(exp_sh));
        step();
        check_val({tag, "_pulse"}, 64'(s_tilde_en), 64'd0);
        check_val({tag, "_hold"}, 64'(s_tilde), 64'(exp_st));
    endtask

    initial begin
        logic [63:0] rnd;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 49'sd0, 14'd0, 1'b0, 1'b0, 12'd0);
        repeat (3) step();
        check_val("rst_en", 64'(s_tilde_en), 64'd0);
        check_val("rst_st", 64'(s_tilde), 64'd0);
        check_val("rst_sh", 64'(s_hat), 64'd0);
        rst_n = 1'b1;

        // Nominal pair, back-to-back.
        step();
        drive(1'b1, 49'sd0, 14'd8192, 1'b0, 1'b0, 12'd0);
        step();
        drive(1'b1, 49'sd100 <<< 17, 14'd8192, 1'b0, 1'b0, 12'd0);
        check_val("b2b_early", 64'(s_tilde_en), 64'd0);
        step();
        drive(1'b0, 49'sd0, 14'd0, 1'b0, 1'b0, 12'd0);
        check_val("b2b_a_en", 64'(s_tilde_en), 64'd1);
        check_val("b2b_a_st", 64'(s_tilde), 64'd4097);
        check_val("b2b_a_sh", 64'(s_hat), 64'd2048);
        step();
        check_val("b2b_b_en", 64'(s_tilde_en), 64'd1);
        check_val("b2b_b_st", 64'(s_tilde), 64'd4197);
        check_val("b2b_b_sh", 64'(s_hat), 64'd2098);
        step();
        check_val("b2b_end", 64'(s_tilde_en), 64'd0);

        // Floor toward -inf.
        one_sample("neg1", -49'sd1, 14'd8192, 1'b0, 1'b0, 12'd0, 13'd4096, 12'd2048);
        one_sample("neg2", -(49'sd1 <<< 17), 14'd8192, 1'b0, 1'b0, 12'd0, 13'd4096, 12'd2048);

        // Clip boundaries.
        one_sample("hi_exact", 49'sd0, 14'd16380, 1'b0, 1'b0, 12'd0, 13'd8191, 12'd4095);
        one_sample("hi_clip", 49'sd10 <<< 17, 14'd16380, 1'b0, 1'b0, 12'd0, 13'd8191, 12'd4095);
        one_sample("lo_exact", 49'sd0, 14'd0, 1'b0, 1'b0, 12'd0, 13'd1, 12'd0);
        one_sample("lo_clip", -(49'sd5 <<< 17), 14'd0, 1'b0, 1'b0, 12'd0, 13'd0, 12'd0);

        // mod*_R wrap: 2^31 wraps to -2^31, giving a clipped 0 rather than 8191.
        one_sample("wrap", 49'sd1 <<< 31, 14'd8192, 1'b0, 1'b0, 12'd0, 13'd0, 12'd0);

        // First sample of a band.
        rnd = {$urandom(), $urandom()};
        one_sample("first_prev", $signed(rnd[48:0]), rnd[61:48], 1'b1, 1'b0, 12'd1234,
                   13'd2468, 12'd1234);
        rnd = {$urandom(), $urandom()};
        one_sample("first_bz", $signed(rnd[48:0]), rnd[61:48], 1'b1, 1'b1, 12'd777,
                   13'd4096, 12'd2048);

        // Reset while two samples are in flight.
        step();
        drive(1'b1, 49'sd0, 14'd8192, 1'b0, 1'b0, 12'd0);
        step();
        drive(1'b1, 49'sd100 <<< 17, 14'd8192, 1'b0, 1'b0, 12'd0);
        rst_n = 1'b0;
        step();
        drive(1'b0, 49'sd0, 14'd0, 1'b0, 1'b0, 12'd0);
        rst_n = 1'b1;
        check_val("mid_rst_en", 64'(s_tilde_en), 64'd0);
        check_val("mid_rst_st", 64'(s_tilde), 64'd0);
        check_val("mid_rst_sh", 64'(s_hat), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("mid_rst_quiet", 64'(s_tilde_en), 64'd0);
        end
        one_sample("post_rst", 49'sd100 <<< 17, 14'd8192, 1'b0, 1'b0, 12'd0, 13'd4197, 12'd2098);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
